leaderboard_ctrl: RTL and testbench
===================================

// Module: leaderboard_ctrl
// PURPOSE
//  Sequences insertion of finished stopwatch times into two sorted top-DEPTH tables (FAST: smaller wins; SLOW: larger wins).
//  Sits between the stopwatch core (time source) and the display/sound logic.
//  Replaces level-triggered insertion with a valid/ready handshake and a multi-cycle compare/shift FSM.
//  Also owns display-slot selection and one-cycle rank sound pulses.
// PARAMETERS
//  TIME_W  39  width of a time value
//  DEPTH   3   entries per table (rank 1..DEPTH)
// PORTS
//  clk           in   1       system clock; all state on rising edge
//  reset         in   1       synchronous, active-high; clears all state
//  in_valid      in   1       time_in/mode_in valid
//  in_ready      out  1       high only in IDLE; transfer = in_valid & in_ready
//  time_in       in   TIME_W  finished time
//  mode_in       in   2       01=SLOW, 10=FAST, other=invalid
//  clear         in   1       wipe both tables, abort any insertion
//  disp_next     in   1       1-cycle pulse (debounced): advance display slot
//  res_valid     out  1       1-cycle pulse: insertion finished
//  res_rank      out  2       rank placed 1..DEPTH, 0 = not placed; valid with res_valid
//  sound         out  DEPTH   one-hot 1-cycle pulse, bit r-1 for rank r, with res_valid
//  disp_time     out  TIME_W  entry under display_sel, 0 if empty/OFF
//  disp_led      out  3       thermometer rank: 001/011/111, 000 for OFF
//  slow_or_fast  out  2       11 FAST slot, 01 SLOW slot, 00 OFF
// BEHAVIOUR
//  Reset values: all entries 0 + entry-valid 0; FSM IDLE; in_ready=1; res_valid=0; res_rank=0; sound=0; display_sel=OFF (disp_* = 0).
//  FSM: IDLE -> CMP -> (INS | DONE) -> DONE -> IDLE.
//   IDLE: on transfer latch time/mode; idx=0; go CMP. Invalid mode: go DONE directly, rank 0.
//   CMP: one entry per cycle at idx. Hit if entry empty or new strictly better (FAST t<e, SLOW t>e).
//        Hit -> INS at idx. Miss & idx==DEPTH-1 -> DONE rank 0. Else idx++.
//   INS: entries idx..DEPTH-2 shift down one, entry DEPTH-1 dropped, time written at idx, valid set. -> DONE.
//   DONE: res_valid=1, res_rank=idx+1 (or 0), sound one-hot; -> IDLE.
//  Ties: new time ranks BELOW an equal existing entry (strict compare); ties into a full table at bottom rank are rejected.
//  Latency (transfer cycle = 0): rank r -> res_valid at cycle r+2; rejected -> DEPTH+1; invalid mode -> 1.
//  Only the table selected by the latched mode changes; the other is untouched.
//  in_ready=0 outside IDLE; in_valid then ignored (no queueing). Back-to-back transfers allowed on the cycle after DONE.
//  clear: priority over everything except reset; next cycle both tables empty, FSM IDLE, no res_valid for the aborted insert.
//   clear coincident with a transfer: clear wins, input dropped.
//  Display: display_sel cycles OFF->F1->F2->F3->S1->S2->S3->OFF on each disp_next; wraps.
//   disp_* combinational from display_sel and table contents; update same cycle as an INS write.
//   disp_next is honored in every FSM state and during clear; reset returns display_sel to OFF.
//  Arithmetic: unsigned TIME_W compares only; no saturation needed.
// STRUCTURE
//  leaderboard_pkg: TIME_W, DEPTH, MODE_SLOW=2'b01, MODE_FAST=2'b10, FSM state encodings, display_sel encodings.
//  Sub-module lb_table (param TIME_W, DEPTH, SMALLER_WINS): entry array + valid bits, per-index compare output, insert-at-idx shift.
//   Two instances: FAST (SMALLER_WINS=1) and SLOW (SMALLER_WINS=0).
//  leaderboard_ctrl holds the FSM, idx counter, latched input, display_sel and the output mux.
// TESTING
//  1. reset, then FAST 500 -> rank1 at cycle 3; sound=001; disp F1=500, disp_led=001, slow_or_fast=11.
//  2. FAST 300, 700, 400 after (1) -> ranks 1, 3, 2; table = 300, 400, 500.
//     FAST 900 -> rank 0 at cycle 4, table unchanged.
//  3. SLOW 10, 10 -> ranks 1, 2 (tie below); FAST table unaffected; mode 11 -> rank 0 at cycle 1.
//  4. in_valid held high through busy -> exactly one transfer per IDLE; in_ready low during CMP/INS/DONE.
//  5. clear during CMP of 3rd insert -> no res_valid, all disp_time 0; reset mid-INS -> table contents all 0.
//  6. 7 disp_next pulses -> OFF, F1..F3, S1..S3, OFF; disp_led 000, 001, 011, 111, 001, 011, 111, 000.

Source files
------------

// File: rtl/leaderboard_pkg.sv
// Shared widths, mode codes, FSM and display-slot encodings for the leaderboard controller.
package leaderboard_pkg;
  localparam int TIME_W = 39;
  localparam int DEPTH  = 3;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_INS, ST_DONE} state_t;

  typedef enum logic [2:0] {DS_OFF, DS_F1, DS_F2, DS_F3, DS_S1, DS_S2, DS_S3} disp_sel_t;

  // Thermometer LED pattern for a 1-based rank; 0 means no slot shown.
  function automatic logic [2:0] rank_led(input logic [1:0] rank);
    case (rank)
      2'd1:    rank_led = 3'b001;
      2'd2:    rank_led = 3'b011;
      2'd3:    rank_led = 3'b111;
      default: rank_led = 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/leaderboard_ctrl_if.sv
// Insertion request / result bundle between the stopwatch core and the leaderboard controller.
interface leaderboard_ctrl_if;
  import leaderboard_pkg::*;

  // Request: a transfer happens on a rising edge where in_valid & in_ready; nothing is queued
  // while in_ready is low. Result: res_valid is a one-cycle pulse carrying res_rank and sound.
  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] time_in;
  logic [1:0]        mode_in;
  logic              res_valid;
  logic [1:0]        res_rank;
  logic [DEPTH-1:0]  sound;

  modport master (output in_valid, time_in, mode_in,
                  input  in_ready, res_valid, res_rank, sound);
  modport slave  (input  in_valid, time_in, mode_in,
                  output in_ready, res_valid, res_rank, sound);
endinterface

// File: rtl/lb_table.sv
// One sorted top-DEPTH table: entries plus valid bits, a compare at idx and insert-with-shift at idx.
module lb_table #(
  parameter int  TIME_W       = 39,
  parameter int  DEPTH        = 3,
  parameter bit  SMALLER_WINS = 1'b1,
  localparam int IDX_W        = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [IDX_W-1:0]              idx,
  input  logic [TIME_W-1:0]             new_time,
  input  logic                          ins,
  output logic                          hit,
  output logic [DEPTH-1:0][TIME_W-1:0]  entry,
  output logic [DEPTH-1:0]              valid
);
  logic better;

  // Strict compare: an equal time never displaces an existing entry.
  always_comb begin
    better = SMALLER_WINS ? (new_time < entry[idx]) : (new_time > entry[idx]);
    hit    = !valid[idx] || better;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      entry <= '0;
      valid <= '0;
    end else if (ins) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (i > int'(idx)) begin
          entry[i] <= entry[i-1];
          valid[i] <= valid[i-1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(idx)) begin
          entry[i] <= new_time;
          valid[i] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/leaderboard_ctrl.sv
// Insertion sequencer for the FAST/SLOW leaderboards, plus display-slot selection and rank sound pulses.
module leaderboard_ctrl
  import leaderboard_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  leaderboard_ctrl_if.slave  bus,
  input  logic               clear,
  input  logic               disp_next,
  output logic [TIME_W-1:0]  disp_time,
  output logic [2:0]         disp_led,
  output logic [1:0]         slow_or_fast,
  output state_t             dbg_state
);
  state_t                     state;
  disp_sel_t                  display_sel;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           slot;
  logic [TIME_W-1:0]          lat_time;
  logic [1:0]                 lat_mode;
  logic                       fast_hit, slow_hit, hit;
  logic [DEPTH-1:0][TIME_W-1:0] fast_entry, slow_entry;
  logic [DEPTH-1:0]           fast_valid, slow_valid;

  assign hit       = (lat_mode == MODE_FAST) ? fast_hit : slow_hit;
  assign dbg_state = state;

  lb_table #(.TIME_W(TIME_W), .DEPTH(DEPTH), .SMALLER_WINS(1'b1)) u_fast (
    .clk, .reset, .clear, .idx, .new_time(lat_time),
    .ins(state == ST_INS && lat_mode == MODE_FAST),
    .hit(fast_hit), .entry(fast_entry), .valid(fast_valid)
  );

  lb_table #(.TIME_W(TIME_W), .DEPTH(DEPTH), .SMALLER_WINS(1'b0)) u_slow (
    .clk, .reset, .clear, .idx, .new_time(lat_time),
    .ins(state == ST_INS && lat_mode == MODE_SLOW),
    .hit(slow_hit), .entry(slow_entry), .valid(slow_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      lat_time      <= '0;
      lat_mode      <= '0;
      bus.in_ready  <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_rank  <= '0;
      bus.sound     <= '0;
      display_sel   <= DS_OFF;
    end else begin
      if (disp_next)
        display_sel <= (display_sel == DS_S3) ? DS_OFF : disp_sel_t'(display_sel + 3'd1);
      bus.res_valid <= 1'b0;
      bus.res_rank  <= '0;
      bus.sound     <= '0;
      if (clear) begin
        // Aborts any insertion silently; the tables wipe themselves on the same edge.
        state        <= ST_IDLE;
        idx          <= '0;
        bus.in_ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
              lat_time     <= bus.time_in;
              lat_mode     <= bus.mode_in;
              idx          <= '0;
              bus.in_ready <= 1'b0;
              if (bus.mode_in == MODE_FAST || bus.mode_in == MODE_SLOW) begin
                state <= ST_CMP;
              end else begin
                state         <= ST_DONE;
                bus.res_valid <= 1'b1;
              end
            end
          end
          ST_CMP: begin
            if (hit) begin
              state <= ST_INS;
            end else if (idx == IDX_W'(DEPTH - 1)) begin
              state         <= ST_DONE;
              bus.res_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          ST_INS: begin
            state         <= ST_DONE;
            bus.res_valid <= 1'b1;
            bus.res_rank  <= 2'(idx) + 2'd1;
            bus.sound     <= DEPTH'(1) << idx;
          end
          default: begin
            state        <= ST_IDLE;
            bus.in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    disp_time    = '0;
    disp_led     = 3'b000;
    slow_or_fast = 2'b00;
    slot         = '0;
    case (display_sel)
      DS_F1, DS_F2, DS_F3: begin
        slot         = IDX_W'(display_sel - DS_F1);
        disp_time    = fast_valid[slot] ? fast_entry[slot] : '0;
        disp_led     = rank_led(2'(slot) + 2'd1);
        slow_or_fast = 2'b11;
      end
      DS_S1, DS_S2, DS_S3: begin
        slot         = IDX_W'(display_sel - DS_S1);
        disp_time    = slow_valid[slot] ? slow_entry[slot] : '0;
        disp_led     = rank_led(2'(slot) + 2'd1);
        slow_or_fast = 2'b01;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_leaderboard_ctrl.sv
// Directed plus randomized bench for leaderboard_ctrl against a queue-based ranking model.
module tb_leaderboard_ctrl;
  import leaderboard_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              disp_next;
  logic [TIME_W-1:0] disp_time;
  logic [2:0]        disp_led;
  logic [1:0]        slow_or_fast;
  state_t            dbg_state;

  leaderboard_ctrl_if bus();

  leaderboard_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus), .clear(clear), .disp_next(disp_next),
    .disp_time(disp_time), .disp_led(disp_led), .slow_or_fast(slow_or_fast),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [TIME_W-1:0] fast_q[$];
  logic [TIME_W-1:0] slow_q[$];
  logic [23:0]       exp_q[$];
  int                model_sel = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rank = 1 + number of entries at least as good as t; beyond DEPTH it is rejected.
  function automatic int model_insert(input logic [1:0] mode, input logic [TIME_W-1:0] t);
    int pos = 0;
    if (mode == MODE_FAST) begin
      while (pos < fast_q.size() && !(t < fast_q[pos])) pos++;
      if (pos >= DEPTH) return 0;
      fast_q.insert(pos, t);
      if (fast_q.size() > DEPTH) void'(fast_q.pop_back());
      return pos + 1;
    end else if (mode == MODE_SLOW) begin
      while (pos < slow_q.size() && !(t > slow_q[pos])) pos++;
      if (pos >= DEPTH) return 0;
      slow_q.insert(pos, t);
      if (slow_q.size() > DEPTH) void'(slow_q.pop_back());
      return pos + 1;
    end
    return 0;
  endfunction

  function automatic int model_latency(input logic [1:0] mode, input int rank);
    if (mode != MODE_FAST && mode != MODE_SLOW) return 1;
    return (rank == 0) ? DEPTH + 1 : rank + 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] mode, input logic [TIME_W-1:0] t, input string tag);
    int exp_rank, exp_lat, lat;
    bit seen;
    @(negedge clk);
    check({tag, "_ready_idle"}, 64'(bus.in_ready), 64'd1);
    exp_rank = model_insert(mode, t);
    exp_lat  = model_latency(mode, exp_rank);
    bus.in_valid = 1'b1;
    bus.time_in  = t;
    bus.mode_in  = mode;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      bus.in_valid = 1'b0;
      check({tag, "_ready_busy"}, 64'(bus.in_ready), 64'd0);
      if (bus.res_valid) begin
        seen = 1'b1;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rank"}, 64'(bus.res_rank), 64'(exp_rank));
        check({tag, "_sound"}, 64'(bus.sound), (exp_rank == 0) ? 64'd0 : (64'd1 << (exp_rank - 1)));
      end
    end
    check({tag, "_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    fast_q.delete();
    slow_q.delete();
  endtask

  // Walk all seven display slots and back to OFF, checking each against the model tables.
  task automatic check_display(input string tag);
    int k;
    logic [TIME_W-1:0] exp_t;
    @(negedge clk);
    for (int s = 0; s <= 7; s++) begin
      k = (model_sel == 0) ? 0 : ((model_sel - 1) % 3) + 1;
      exp_t = '0;
      if (model_sel >= 1 && model_sel <= 3 && fast_q.size() >= k) exp_t = fast_q[k-1];
      if (model_sel >= 4 && slow_q.size() >= k) exp_t = slow_q[k-1];
      check($sformatf("%s_time_sel%0d", tag, model_sel), 64'(disp_time), 64'(exp_t));
      check($sformatf("%s_led_sel%0d", tag, model_sel), 64'(disp_led), 64'((1 << k) - 1));
      check($sformatf("%s_sof_sel%0d", tag, model_sel), 64'(slow_or_fast),
            (model_sel == 0) ? 64'd0 : (model_sel <= 3) ? 64'd3 : 64'd1);
      if (s < 7) begin
        disp_next = 1'b1;
        @(negedge clk);
        disp_next = 1'b0;
        model_sel = (model_sel + 1) % 7;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, r, lat, t_cyc, exp_ready;
    logic [1:0]  mode;
    logic [63:0] rnd;
    int tr_q[$];
    logic [23:0] e;

    reset = 1'b1; clear = 1'b0; disp_next = 1'b0;
    bus.in_valid = 1'b0; bus.time_in = '0; bus.mode_in = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_rank", 64'(bus.res_rank), 64'd0);
    check("rst_sound", 64'(bus.sound), 64'd0);
    check("rst_disp_time", 64'(disp_time), 64'd0);
    check("rst_disp_led", 64'(disp_led), 64'd0);
    check("rst_sof", 64'(slow_or_fast), 64'd0);

    // 1: first FAST entry, then the display walk
    issue(MODE_FAST, 39'd500, "t1_fast500");
    check_display("t1_disp");

    // 2: ordering and rejection in the FAST table
    issue(MODE_FAST, 39'd300, "t2_fast300");
    issue(MODE_FAST, 39'd700, "t2_fast700");
    issue(MODE_FAST, 39'd400, "t2_fast400");
    issue(MODE_FAST, 39'd900, "t2_fast900");
    check_display("t2_disp");

    // 3: SLOW ties, invalid modes, FAST untouched
    issue(MODE_SLOW, 39'd10, "t3_slow10a");
    issue(MODE_SLOW, 39'd10, "t3_slow10b");
    issue(2'b11, 39'd5, "t3_mode11");
    issue(2'b00, 39'd5, "t3_mode00");
    issue(MODE_FAST, 39'd400, "t3_fast_tie_full");
    check_display("t3_disp");

    // randomized traffic, small values favour ties
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? MODE_FAST : MODE_SLOW;
      rnd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rnd = 64'($urandom_range(0, 15));
      issue(mode, rnd[TIME_W-1:0], $sformatf("rnd%0d", n));
      if (n % 8 == 7) check_display($sformatf("rnd_disp%0d", n));
    end

    // 4: in_valid held high through busy periods
    clear_pulse();
    t_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      r   = model_insert(MODE_FAST, 39'd50);
      lat = model_latency(MODE_FAST, r);
      tr_q.push_back(t_cyc);
      exp_q.push_back({16'(t_cyc + lat), 8'(r)});
      t_cyc = t_cyc + lat + 1;
    end
    @(negedge clk);
    check("held_ready_c0", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.time_in = 39'd50; bus.mode_in = MODE_FAST;
    pulses = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      exp_ready = 0;
      foreach (tr_q[i]) if (tr_q[i] == k) exp_ready = 1;
      check($sformatf("held_ready_c%0d", k), 64'(bus.in_ready), 64'(exp_ready));
      if (bus.res_valid) begin
        pulses++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("held_res_cycle%0d", pulses), 64'(k), 64'(e[23:8]));
          check($sformatf("held_res_rank%0d", pulses), 64'(bus.res_rank), 64'(e[7:0]));
        end
      end
    end
    bus.in_valid = 1'b0;
    check("held_res_count", 64'(pulses), 64'd4);
    check("held_exp_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check_display("t4_disp");

    // 5a: clear during CMP of the third insert
    clear_pulse();
    issue(MODE_FAST, 39'd8, "t5_fast8");
    issue(MODE_FAST, 39'd9, "t5_fast9");
    @(negedge clk);
    bus.in_valid = 1'b1; bus.time_in = 39'd7; bus.mode_in = MODE_FAST;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    fast_q.delete();
    slow_q.delete();
    check("t5_clear_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t5_clear_no_res%0d", k), 64'(bus.res_valid), 64'd0);
      @(negedge clk);
    end
    check_display("t5_clear_disp");

    // 5b: reset landing on the INS cycle
    issue(MODE_SLOW, 39'd33, "t5_slow33");
    @(negedge clk);
    bus.in_valid = 1'b1; bus.time_in = 39'd5; bus.mode_in = MODE_FAST;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fast_q.delete();
    slow_q.delete();
    model_sel = 0;
    check("t5_rst_ready", 64'(bus.in_ready), 64'd1);
    check("t5_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_display("t5_rst_disp");

    // 6: display wrap after a fresh entry in each table
    issue(MODE_FAST, 39'd123, "t6_fast123");
    issue(MODE_SLOW, 39'd456, "t6_slow456");
    check_display("t6_disp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
